// File: rtl/video_frame_guard_if.sv
// ----------------------------------------------------------------------------
// axi4_stream_if
// Pixel AXI4-Stream bundle used on both sides of video_frame_guard.
//   tvalid / tready : handshake
//   tdata           : pixel value, DATA_W bits
//   tuser           : frame start, set on the first pixel of a frame
//   tlast           : end of line, set on the last pixel of a line
// The master modport drives the payload; the slave modport drives tready.
// ----------------------------------------------------------------------------
interface axi4_stream_if #(
    parameter int DATA_W = 10
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_frame_guard.sv
// ----------------------------------------------------------------------------
// video_frame_guard
// Checks a pixel AXI4-Stream against a fixed frame geometry and forwards only
// frames that started cleanly. After a geometry error every beat is dropped
// until the next frame start, so downstream IP never sees a partial frame.
//
// Ports:
//   clk_i        pixel clock
//   rst_n_i      asynchronous active-low reset
//   video_i      input pixel stream (slave)
//   video_o      guarded pixel stream (master), one register stage
//   locked_o     high while frames are being passed
//   line_err_o   one-cycle pulse after a line-length error
//   frame_err_o  one-cycle pulse after a frame-height error
//   frame_cnt_o  count of complete good frames, wraps at 16 bits
// ----------------------------------------------------------------------------
module video_frame_guard #(
    parameter int PX_WIDTH     = 10,
    parameter int FRAME_WIDTH  = 1920,
    parameter int FRAME_HEIGHT = 1080
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    axi4_stream_if.slave  video_i,
    axi4_stream_if.master video_o,
    output logic          locked_o,
    output logic          line_err_o,
    output logic          frame_err_o,
    output logic [15:0]   frame_cnt_o
);

    localparam int PX_W = $clog2(FRAME_WIDTH);
    localparam int LN_W = $clog2(FRAME_HEIGHT + 1);

    localparam logic [PX_W-1:0] PX_LAST = PX_W'(FRAME_WIDTH - 1);
    localparam logic [LN_W-1:0] LN_FULL = LN_W'(FRAME_HEIGHT);
    localparam logic [LN_W-1:0] LN_LAST = LN_W'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [PX_W-1:0]   px_cnt;
    logic [PX_W-1:0]   px_nx;
    logic [LN_W-1:0]   ln_cnt;
    logic [LN_W-1:0]   ln_nx;

    logic              ready;
    logic              accept;
    logic              fwd;
    logic              line_err_nx;
    logic              frame_err_nx;
    logic              frame_done;

    logic              vld_p1;
    logic [PX_WIDTH-1:0] data_p1;
    logic              user_p1;
    logic              last_p1;
    logic              line_err_p1;
    logic              frame_err_p1;
    logic [15:0]       frame_cnt;

    // Dropped beats obey the same ready rule as forwarded ones, so the guard
    // never throttles upstream harder than the output register does.
    assign ready         = !vld_p1 || video_o.tready;
    assign accept        = video_i.tvalid && ready;
    assign video_i.tready = ready;

    always_comb begin
        state_nx     = state;
        px_nx        = px_cnt;
        ln_nx        = ln_cnt;
        fwd          = 1'b0;
        line_err_nx  = 1'b0;
        frame_err_nx = 1'b0;
        frame_done   = 1'b0;

        if (accept) begin
            if (video_i.tuser) begin
                fwd      = 1'b1;
                px_nx    = PX_W'(1);
                ln_nx    = '0;
                state_nx = PASS;
                if (state == PASS) begin
                    // A frame that finished all its lines parks at
                    // ln_cnt == FRAME_HEIGHT, px_cnt == 0; anything else
                    // still in progress means the old frame was cut short.
                    if (!(ln_cnt == LN_FULL && px_cnt == '0) &&
                        (ln_cnt != '0 || px_cnt != '0)) begin
                        frame_err_nx = 1'b1;
                    end
                    if (px_cnt != '0) begin
                        line_err_nx = 1'b1;
                    end
                end
                // The start pixel counts as pixel 0; with FRAME_WIDTH >= 2 a
                // tlast on it is always a short line.
                if (video_i.tlast) begin
                    line_err_nx = 1'b1;
                    state_nx    = DROP;
                end
            end else if (state == PASS) begin
                if (ln_cnt == LN_FULL) begin
                    // Extra line after a complete frame: drop it.
                    frame_err_nx = 1'b1;
                    state_nx     = DROP;
                end else begin
                    fwd = 1'b1;
                    if (video_i.tlast) begin
                        if (px_cnt == PX_LAST) begin
                            px_nx      = '0;
                            ln_nx      = ln_cnt + 1'b1;
                            frame_done = (ln_cnt == LN_LAST);
                        end else begin
                            line_err_nx = 1'b1;
                            state_nx    = DROP;
                        end
                    end else if (px_cnt == PX_LAST) begin
                        line_err_nx = 1'b1;
                        state_nx    = DROP;
                    end else begin
                        px_nx = px_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            px_cnt       <= '0;
            ln_cnt       <= '0;
            line_err_p1  <= 1'b0;
            frame_err_p1 <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            state        <= state_nx;
            px_cnt       <= px_nx;
            ln_cnt       <= ln_nx;
            line_err_p1  <= line_err_nx;
            frame_err_p1 <= frame_err_nx;
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // ---- output register stage (p1) ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            user_p1 <= 1'b0;
            last_p1 <= 1'b0;
        end else if (ready) begin
            vld_p1 <= fwd;
            if (fwd) begin
                data_p1 <= video_i.tdata;
                user_p1 <= video_i.tuser;
                last_p1 <= video_i.tlast;
            end
        end
    end

    assign video_o.tvalid = vld_p1;
    assign video_o.tdata  = data_p1;
    assign video_o.tuser  = user_p1;
    assign video_o.tlast  = last_p1;

    assign locked_o    = (state == PASS);
    assign line_err_o  = line_err_p1;
    assign frame_err_o = frame_err_p1;
    assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_video_frame_guard.sv
// ----------------------------------------------------------------------------
// tb_video_frame_guard
// Scoreboard bench for video_frame_guard with an 8x4 frame geometry. Each
// beat is pushed to the expected queue when driven (if it should come out)
// and popped when the DUT hands it over on video_o.
// ----------------------------------------------------------------------------
module tb_video_frame_guard;

    localparam int PXW = 10;
    localparam int FW  = 8;
    localparam int FH  = 4;

    logic clk;
    logic rst_n;
    logic locked;
    logic line_err;
    logic frame_err;
    logic [15:0] frame_cnt;

    axi4_stream_if #(.DATA_W(PXW)) vin ();
    axi4_stream_if #(.DATA_W(PXW)) vout ();

    video_frame_guard #(
        .PX_WIDTH    (PXW),
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .video_i    (vin),
        .video_o    (vout),
        .locked_o   (locked),
        .line_err_o (line_err),
        .frame_err_o(frame_err),
        .frame_cnt_o(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_lerr   = 0;
    int n_ferr   = 0;
    int n_both   = 0;
    int exp_lerr = 0;
    int exp_ferr = 0;
    int exp_frames = 0;
    bit bp_hold  = 1'b0;

    logic [11:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Output backpressure: random unless held low.
    initial begin
        vout.tready = 1'b1;
        forever begin
            @(negedge clk);
            vout.tready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor and pulse counters.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (vout.tvalid && vout.tready) begin
                chk("beat_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", {20'd0, vout.tuser, vout.tlast, vout.tdata}, {20'd0, e});
                end
            end
            if (line_err)  n_lerr++;
            if (frame_err) n_ferr++;
            if (line_err && frame_err) n_both++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic idle();
        vin.tvalid = 1'b0;
        vin.tuser  = 1'b0;
        vin.tlast  = 1'b0;
    endtask

    // Called right after a negedge; returns on the negedge after acceptance.
    task automatic send(input logic [PXW-1:0] d, input bit u, input bit l, input bit f);
        int guard;
        vin.tvalid = 1'b1;
        vin.tdata  = d;
        vin.tuser  = u;
        vin.tlast  = l;
        if (f) exp_q.push_back({u, l, d});
        guard = 0;
        forever begin
            #2;
            if (vin.tready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                chk("accept_timeout", guard, 0);
                break;
            end
        end
    endtask

    // npx beats; tuser on beat 0 if first; tlast on beat last_pos;
    // the first nfwd beats are expected on the output.
    task automatic send_line(input bit first, input int npx, input int last_pos, input int nfwd);
        for (int i = 0; i < npx; i++) begin
            send(PXW'($urandom_range(0, 1023)), first && (i == 0), (i == last_pos), (i < nfwd));
        end
    endtask

    task automatic send_frame();
        for (int l = 0; l < FH; l++) send_line(l == 0, FW, FW - 1, FW);
        exp_frames++;
    endtask

    task automatic drain_and_check(input string tag);
        int g;
        idle();
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_frame_cnt"}, frame_cnt, exp_frames);
        chk({tag, "_line_err"}, n_lerr, exp_lerr);
        chk({tag, "_frame_err"}, n_ferr, exp_ferr);
    endtask

    initial begin
        logic [12:0] snap;
        bit stable;
        bit in_low;

        rst_n = 1'b0;
        vin.tdata = '0;
        idle();
        #2;
        chk("rst_tvalid", vout.tvalid, 0);
        chk("rst_tdata", {vout.tuser, vout.tlast, vout.tdata}, 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_errs", {line_err, frame_err}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pre-lock junk, then a good frame.
        for (int i = 0; i < 5; i++) send(PXW'($urandom_range(0, 1023)), 0, (i == 4), 0);
        chk("junk_locked", locked, 0);
        send(PXW'($urandom_range(0, 1023)), 1, 0, 1);
        chk("lock_after_tuser", locked, 1);
        send_line(0, FW - 1, FW - 2, FW - 1);
        for (int l = 1; l < FH; l++) send_line(0, FW, FW - 1, FW);
        exp_frames++;
        drain_and_check("junk");

        // Clean frames.
        for (int f = 0; f < 3; f++) send_frame();
        drain_and_check("clean");
        chk("clean_locked", locked, 1);

        // Short line on line 1.
        send_line(1, FW, FW - 1, FW);
        send_line(0, 6, 5, 6);
        exp_lerr++;
        chk("short_line_locked", locked, 0);
        send_line(0, FW, FW - 1, 0);
        send_line(0, FW, FW - 1, 0);
        send_frame();
        drain_and_check("short_line");

        // Long line on line 2.
        send_line(1, FW, FW - 1, FW);
        send_line(0, FW, FW - 1, FW);
        send_line(0, FW + 1, FW, FW);
        exp_lerr++;
        chk("long_line_locked", locked, 0);
        send_line(0, FW, FW - 1, 0);
        send_frame();
        drain_and_check("long_line");

        // Short frame: new tuser after 2 good lines.
        send_line(1, FW, FW - 1, FW);
        send_line(0, FW, FW - 1, FW);
        send_frame();
        exp_ferr++;
        drain_and_check("short_frame");

        // Tall frame: extra 5th line dropped.
        send_frame();
        send_line(0, FW, FW - 1, 0);
        exp_ferr++;
        chk("tall_locked", locked, 0);
        send_frame();
        drain_and_check("tall_frame");

        // tuser mid-line: both pulses in the same cycle.
        send_line(1, FW, FW - 1, FW);
        send_line(0, 3, -1, 3);
        send_frame();
        exp_lerr++;
        exp_ferr++;
        drain_and_check("mid_line_tuser");
        chk("both_same_cycle", n_both, 1);

        // Backpressure held for 10 cycles mid-line.
        bp_hold = 1'b1;
        vout.tready = 1'b0;
        fork
            send_frame();
        join_none
        repeat (4) @(negedge clk);
        #2;
        snap = {vout.tvalid, vout.tuser, vout.tlast, vout.tdata};
        stable = 1'b1;
        in_low = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #2;
            if ({vout.tvalid, vout.tuser, vout.tlast, vout.tdata} !== snap) stable = 1'b0;
            if (vin.tready) in_low = 1'b0;
        end
        chk("bp_tvalid", vout.tvalid, 1);
        chk("bp_stable", stable, 1);
        chk("bp_in_tready_low", in_low, 1);
        bp_hold = 1'b0;
        wait fork;
        drain_and_check("backpressure");

        // Reset mid-line.
        send(PXW'($urandom_range(0, 1023)), 1, 0, 1);
        send_line(0, 3, -1, 3);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        #1;
        chk("midrst_tvalid", vout.tvalid, 0);
        chk("midrst_payload", {vout.tuser, vout.tlast, vout.tdata}, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_line(0, 3, 2, 0);
        chk("post_rst_locked", locked, 0);
        send_frame();
        drain_and_check("post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_frame_guard.md
# video_frame_guard

Downstream stage of the CSI-2 receiver. It sits in the pixel-clock domain and consumes the serialized 10-bit pixel AXI4-Stream (tuser = frame start, tlast = end of line). It checks every line and frame against the configured geometry and forwards only frames that started cleanly. After a geometry error it drops beats until the next frame start, so downstream video IP never sees a partial or misaligned frame.

## Interface
Parameters:
- PX_WIDTH, 10, pixel bits carried in tdata[PX_WIDTH-1:0]
- FRAME_WIDTH, 1920, pixels per line; must be ≥ 2
- FRAME_HEIGHT, 1080, lines per frame; must be ≥ 2

Ports:
- clk_i, input, 1, pixel clock
- rst_n_i, input, 1, reset; asynchronous assert, active-low
- video_i, axi4_stream_if.slave, PX_WIDTH data + tuser + tlast, input pixel stream
- video_o, axi4_stream_if.master, PX_WIDTH data + tuser + tlast, guarded pixel stream
- locked_o, output, 1, high while in PASS state
- line_err_o, output, 1, one-cycle pulse on a line-length error
- frame_err_o, output, 1, one-cycle pulse on a frame-height error
- frame_cnt_o, output, 16, count of complete good frames; wraps at 0xFFFF→0

## Operation
- Beat accepted = video_i.tvalid && video_i.tready.
- Counters:
  - px_cnt, $clog2(FRAME_WIDTH) bits: pixel index within the line.
  - ln_cnt, $clog2(FRAME_HEIGHT+1) bits: line index within the frame.
- FSM states: IDLE (reset state), PASS, DROP.
- Any accepted beat with tuser=1, in any state:
  - Go to PASS. Forward the beat. Set px_cnt=1, ln_cnt=0.
  - If the previous state was PASS and ln_cnt≠0 or px_cnt≠0: the previous frame was short, so pulse frame_err_o.
  - If that previous state was PASS and px_cnt≠0: also pulse line_err_o.
- IDLE or DROP with tuser=0: drop the beat (accept it but do not forward it). Counters hold.
- PASS with tuser=0:
  - A beat arriving with ln_cnt==FRAME_HEIGHT is an extra line. Pulse frame_err_o, drop the beat, go to DROP.
  - Otherwise, forward the beat and evaluate:
    - tlast=1 and px_cnt==FRAME_WIDTH-1: good line. px_cnt←0, ln_cnt++.
    - If that line was the last one (ln_cnt becomes FRAME_HEIGHT): frame_cnt_o++. Stay in PASS. The next tuser beat clears ln_cnt without an error.
    - tlast=1 and px_cnt≠FRAME_WIDTH-1 (short line): pulse line_err_o, go to DROP.
    - tlast=0 and px_cnt==FRAME_WIDTH-1 (long line): pulse line_err_o, go to DROP.
    - Otherwise: px_cnt++.
- The beat that triggers a line error is still forwarded, with tlast as received. All beats after it are dropped.
- The tuser beat is checked like any pixel. If FRAME_WIDTH==1 behaviour is not required, since FRAME_WIDTH ≥ 2.
- locked_o = (state==PASS).

## Timing
- Output is one register stage. video_o.tvalid/tdata/tuser/tlast are registered, so latency is 1 cycle from accept to video_o.tvalid.
- video_i.tready = !video_o.tvalid || video_o.tready (combinational). There are no bubbles at full throughput.
- Dropped beats are accepted under the same tready rule, so a dropped beat never stalls upstream more than a forwarded one would.
- video_o fields hold stable while tvalid && !tready (AXI4-Stream rule).
- line_err_o and frame_err_o are registered and assert in the cycle after the offending accept. Both may pulse in the same cycle.
- frame_cnt_o updates in the cycle after the accept of the last line's tlast.
- Reset (async assert, deassert synchronous to clk_i):
  - State=IDLE, counters=0, frame_cnt_o=0.
  - video_o.tvalid=0, tdata/tuser/tlast=0.
  - locked_o=0, error pulses=0.
- Reset mid-frame discards the output register content. After reset, all beats are dropped until the next tuser.

## Test plan
Use FRAME_WIDTH=8, FRAME_HEIGHT=4, and random video_o.tready backpressure unless stated.
- **Clean frames:** 3 frames of 4×8 beats, tuser on the first beat → 96 beats out, identical data and tuser/tlast. frame_cnt_o=3, no error pulses, locked_o=1 from the cycle after the first tuser.
- **Pre-lock junk:** 5 beats without tuser, then a good frame → the first 5 beats are dropped. Output starts with the tuser beat, frame_cnt_o=1.
- **Short line:** line 1 has tlast on its 6th pixel → that beat is forwarded and line_err_o pulses once. The rest of the frame is dropped, locked_o=0. The next good frame is forwarded and frame_cnt_o increments only for it.
- **Long line:** line 2 has a 9th pixel with tlast=0 on pixel 8 → pixel 8 is forwarded, line_err_o pulses, and the following beats are dropped until tuser.
- **Short and tall frames:**
  - Short frame: tuser after 2 good lines → frame_err_o pulses and the new frame is forwarded from its tuser.
  - Tall frame: a 5th line without tuser → frame_err_o pulses, the 5th line is dropped, and frame_cnt_o still counts the 4-line frame.
- **Backpressure and reset:**
  - With video_o.tready held at 0 for 10 cycles mid-line, the output holds stable and video_i.tready=0.
  - Asserting rst_n_i=0 mid-line clears all outputs immediately.
  - After release, the stream resumes only at the next tuser.
